// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-master Avalon-MM memory arbiter: FSM states, grant owner
// and the full-word byte-lane mask used for instruction fetches.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_M0 = 1'b0,
        GNT_M1 = 1'b1
    } arb_grant_t;

    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin picker: on a tie the master that did not win
// last time is chosen.
module rr_arbiter_2
    import mem_arbiter_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  arb_grant_t last_grant,
    output arb_grant_t grant,
    output logic       valid
);

    // Pick a winner from the current request pair
    always_comb begin
        grant = GNT_M0;
        valid = 1'b0;
        case ({req0, req1})
            2'b10: begin
                grant = GNT_M0;
                valid = 1'b1;
            end
            2'b01: begin
                grant = GNT_M1;
                valid = 1'b1;
            end
            2'b11: begin
                grant = (last_grant == GNT_M0) ? GNT_M1 : GNT_M0;
                valid = 1'b1;
            end
            default: begin
                grant = GNT_M0;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/avalon_mem_arbiter.sv
// Shares one Avalon-MM RAM slave between the instruction (M0) and data (M1) masters,
// registering the winning request and sequencing waitrequest with a fixed latency.
module avalon_mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m0_address,
    input  logic        m0_read,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic [31:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    output logic        s_waitrequest,
    input  logic [31:0] s_readdata
);

    localparam int CNT_W = ($clog2(WAIT_CYCLES + 1) > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : CNT_W'(0);

    arb_state_t        state_r;
    arb_grant_t        grant_r;
    arb_grant_t        last_grant_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [31:0]       s_address_r;
    logic              s_read_r;
    logic              s_write_r;
    logic [31:0]       s_writedata_r;
    logic [3:0]        s_byteenable_r;
    logic              s_waitrequest_r;
    logic              m0_waitrequest_r;
    logic              m1_waitrequest_r;
    arb_grant_t        pick_grant_s;
    logic              pick_valid_s;
    logic              req1_s;

    assign req1_s = m1_read | m1_write;

    rr_arbiter_2 u_rr (
        .req0       (m0_read),
        .req1       (req1_s),
        .last_grant (last_grant_r),
        .grant      (pick_grant_s),
        .valid      (pick_valid_s)
    );

    // Transaction sequencer: grant, count down the wait window, one-cycle ACK, back to IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r          <= IDLE;
            grant_r          <= GNT_M0;
            last_grant_r     <= GNT_M1;
            cnt_r            <= CNT_ZERO;
            s_address_r      <= 32'h0000_0000;
            s_read_r         <= 1'b0;
            s_write_r        <= 1'b0;
            s_writedata_r    <= 32'h0000_0000;
            s_byteenable_r   <= 4'b0000;
            s_waitrequest_r  <= 1'b1;
            m0_waitrequest_r <= 1'b1;
            m1_waitrequest_r <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        grant_r <= pick_grant_s;
                        cnt_r   <= CNT_INIT;
                        if (pick_grant_s == GNT_M0) begin
                            s_address_r    <= m0_address;
                            s_read_r       <= 1'b1;
                            s_write_r      <= 1'b0;
                            s_writedata_r  <= 32'h0000_0000;
                            s_byteenable_r <= BE_WORD;
                        end else begin
                            // A simultaneous read+write from M1 is carried out as a write
                            s_address_r    <= m1_address;
                            s_read_r       <= m1_read & ~m1_write;
                            s_write_r      <= m1_write;
                            s_writedata_r  <= m1_writedata;
                            s_byteenable_r <= m1_byteenable;
                        end
                        if (WAIT_CYCLES == 0) begin
                            state_r         <= ACK;
                            s_waitrequest_r <= 1'b0;
                            if (pick_grant_s == GNT_M0) begin
                                m0_waitrequest_r <= 1'b0;
                            end else begin
                                m1_waitrequest_r <= 1'b0;
                            end
                        end else begin
                            state_r <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r         <= ACK;
                        s_waitrequest_r <= 1'b0;
                        if (grant_r == GNT_M0) begin
                            m0_waitrequest_r <= 1'b0;
                        end else begin
                            m1_waitrequest_r <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ACK: begin
                    state_r          <= IDLE;
                    s_read_r         <= 1'b0;
                    s_write_r        <= 1'b0;
                    s_waitrequest_r  <= 1'b1;
                    m0_waitrequest_r <= 1'b1;
                    m1_waitrequest_r <= 1'b1;
                    last_grant_r     <= grant_r;
                end
                default: begin
                    state_r          <= IDLE;
                    s_read_r         <= 1'b0;
                    s_write_r        <= 1'b0;
                    s_waitrequest_r  <= 1'b1;
                    m0_waitrequest_r <= 1'b1;
                    m1_waitrequest_r <= 1'b1;
                end
            endcase
        end
    end

    assign s_address      = s_address_r;
    assign s_read         = s_read_r;
    assign s_write        = s_write_r;
    assign s_writedata    = s_writedata_r;
    assign s_byteenable   = s_byteenable_r;
    assign s_waitrequest  = s_waitrequest_r;
    assign m0_waitrequest = m0_waitrequest_r;
    assign m1_waitrequest = m1_waitrequest_r;

    // Read data is steered combinationally so it tracks the RAM during the ACK cycle
    assign m0_readdata = (state_r == ACK && grant_r == GNT_M0) ? s_readdata : 32'h0000_0000;
    assign m1_readdata = (state_r == ACK && grant_r == GNT_M1) ? s_readdata : 32'h0000_0000;

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Scoreboard bench: stimulus pushes expected ACKs, monitors pop and compare on each ACK cycle.
module tb_avalon_mem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Main DUT (WAIT_CYCLES = 2)
    logic [31:0] m0_address = 32'h0, m1_address = 32'h0, m1_writedata = 32'h0;
    logic        m0_read = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [3:0]  m1_byteenable = 4'h0;
    logic        m0_waitrequest, m1_waitrequest, s_read, s_write, s_waitrequest;
    logic [31:0] m0_readdata, m1_readdata, s_address, s_writedata;
    logic [3:0]  s_byteenable;
    logic [31:0] s_readdata = 32'h0;

    // Zero-wait DUT
    logic [31:0] z_m0_address = 32'h0, z_m1_address = 32'h0, z_m1_writedata = 32'h0;
    logic        z_m0_read = 1'b0, z_m1_read = 1'b0, z_m1_write = 1'b0;
    logic [3:0]  z_m1_byteenable = 4'hF;
    logic        z_m0_waitrequest, z_m1_waitrequest, z_s_read, z_s_write, z_s_waitrequest;
    logic [31:0] z_m0_readdata, z_m1_readdata, z_s_address, z_s_writedata;
    logic [3:0]  z_s_byteenable;
    logic [31:0] z_s_readdata = 32'h0;

    avalon_mem_arbiter #(.WAIT_CYCLES(2)) u_dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata)
    );

    avalon_mem_arbiter #(.WAIT_CYCLES(0)) u_dut_z (
        .clk(clk), .reset(reset),
        .m0_address(z_m0_address), .m0_read(z_m0_read),
        .m0_waitrequest(z_m0_waitrequest), .m0_readdata(z_m0_readdata),
        .m1_address(z_m1_address), .m1_read(z_m1_read), .m1_write(z_m1_write),
        .m1_writedata(z_m1_writedata), .m1_byteenable(z_m1_byteenable),
        .m1_waitrequest(z_m1_waitrequest), .m1_readdata(z_m1_readdata),
        .s_address(z_s_address), .s_read(z_s_read), .s_write(z_s_write),
        .s_writedata(z_s_writedata), .s_byteenable(z_s_byteenable),
        .s_waitrequest(z_s_waitrequest), .s_readdata(z_s_readdata)
    );

    typedef struct {
        bit          master;
        logic [31:0] addr;
        bit          wr;
        logic [3:0]  be;
        bit          chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t zq[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   swrite_cnt = 0;

    logic [31:0] mem [logic [29:0]];
    logic [31:0] ram_w;
    exp_t        mon_e, zmon_e;
    bit          mon_gm;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic expect_txn(input bit master, input logic [31:0] addr, input bit wr,
                              input logic [3:0] be, input bit chk_data, input logic [31:0] data);
        exp_t e;
        e.master = master; e.addr = addr; e.wr = wr; e.be = be;
        e.chk_data = chk_data; e.data = data;
        sb.push_back(e);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: acts on the falling edge of s_waitrequest
    always @(negedge s_waitrequest) begin
        if (s_write === 1'b1) begin
            ram_w = mem.exists(s_address[31:2]) ? mem[s_address[31:2]] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (s_byteenable[b]) ram_w[8*b +: 8] = s_writedata[8*b +: 8];
            mem[s_address[31:2]] = ram_w;
        end else if (s_read === 1'b1) begin
            s_readdata = mem.exists(s_address[31:2]) ? mem[s_address[31:2]] : 32'h0;
        end
    end

    always @(negedge z_s_waitrequest) begin
        if (z_s_read === 1'b1)
            z_s_readdata = mem.exists(z_s_address[31:2]) ? mem[z_s_address[31:2]] : 32'h0;
    end

    // Main monitor
    always @(negedge clk) begin
        if (s_write === 1'b1) swrite_cnt++;
        if (!reset && (m0_waitrequest === 1'b0 || m1_waitrequest === 1'b0)) begin
            if (m0_waitrequest === 1'b0 && m1_waitrequest === 1'b0)
                chk("dual_ack", 32'(m1_waitrequest), 32'd1);
            mon_gm = (m0_waitrequest === 1'b0) ? 1'b0 : 1'b1;
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_master", 32'(mon_gm), 32'(mon_e.master));
                chk("s_address", s_address, mon_e.addr);
                chk("s_write", 32'(s_write), 32'(mon_e.wr));
                chk("s_read", 32'(s_read), 32'(!mon_e.wr));
                chk("s_byteenable", 32'(s_byteenable), 32'(mon_e.be));
                if (mon_e.chk_data)
                    chk("readdata", mon_gm ? m1_readdata : m0_readdata, mon_e.data);
                chk("other_readdata", mon_gm ? m0_readdata : m1_readdata, 32'h0);
            end
        end
    end

    // Zero-wait monitor
    always @(negedge clk) begin
        if (!reset && z_m1_waitrequest === 1'b0) begin
            if (zq.size() == 0) begin
                chk("z_unexpected_ack", 32'(zq.size()), 32'd1);
            end else begin
                zmon_e = zq.pop_front();
                chk("z_s_address", z_s_address, zmon_e.addr);
                chk("z_readdata", z_m1_readdata, zmon_e.data);
            end
        end
    end

    task automatic m0_txn(input logic [31:0] addr);
        bit done = 1'b0;
        m0_address = addr;
        m0_read = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (m0_waitrequest === 1'b0) done = 1'b1;
        end
        if (!done) chk("m0_timeout", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        m0_read = 1'b0;
    endtask

    task automatic m1_txn(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] be);
        bit done = 1'b0;
        m1_address = addr;
        m1_writedata = data;
        m1_byteenable = be;
        m1_read = rd;
        m1_write = wr;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (m1_waitrequest === 1'b0) done = 1'b1;
        end
        if (!done) chk("m1_timeout", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        m1_read = 1'b0;
        m1_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    int k, lat, sw0;

    initial begin
        mem[30'h2FF0_0000] = 32'h2402_0005;   // 0xBFC00000
        mem[30'h2FF0_0001] = 32'h3C1D_8000;   // 0xBFC00004
        mem[30'h0000_0001] = 32'hCAFE_F00D;   // 0x00000004
        mem[30'h2000_0008] = 32'h1122_3344;   // 0x80000020
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_waitrequest", 32'(s_waitrequest), 32'd1);
        chk("rst_m0_waitrequest", 32'(m0_waitrequest), 32'd1);
        chk("rst_m1_waitrequest", 32'(m1_waitrequest), 32'd1);
        chk("rst_s_read", 32'(s_read), 32'd0);
        chk("rst_s_write", 32'(s_write), 32'd0);
        chk("rst_s_address", s_address, 32'h0);
        chk("rst_s_writedata", s_writedata, 32'h0);
        chk("rst_s_byteenable", 32'(s_byteenable), 32'd0);
        chk("rst_m0_readdata", m0_readdata, 32'h0);
        chk("rst_z_s_waitrequest", 32'(z_s_waitrequest), 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: reset-vector fetch, latency WAIT_CYCLES+1
        k = cyc;
        sw0 = swrite_cnt;
        lat = -1;
        expect_txn(1'b0, 32'hBFC0_0000, 1'b0, 4'b1111, 1'b1, 32'h2402_0005);
        fork
            m0_txn(32'hBFC0_0000);
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (m0_waitrequest === 1'b0) begin
                        lat = cyc - k;
                        break;
                    end
                end
            end
        join
        chk("t1_latency", 32'(lat), 32'd3);
        chk("t1_no_write", 32'(swrite_cnt - sw0), 32'd0);

        // 2: partial write then read back
        expect_txn(1'b1, 32'h8000_0010, 1'b1, 4'b0011, 1'b0, 32'h0);
        m1_txn(1'b0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b0011);
        expect_txn(1'b1, 32'h8000_0010, 1'b0, 4'b1111, 1'b1, 32'h0000_BEEF);
        m1_txn(1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'b1111);

        // 3: tie with last grant M1 -> M0 first
        expect_txn(1'b0, 32'hBFC0_0004, 1'b0, 4'b1111, 1'b1, 32'h3C1D_8000);
        expect_txn(1'b1, 32'h8000_0010, 1'b0, 4'b1111, 1'b1, 32'h0000_BEEF);
        fork
            m0_txn(32'hBFC0_0004);
            m1_txn(1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'b1111);
        join
        // lone M0, then tie with last grant M0 -> M1 first
        expect_txn(1'b0, 32'hBFC0_0000, 1'b0, 4'b1111, 1'b1, 32'h2402_0005);
        m0_txn(32'hBFC0_0000);
        expect_txn(1'b1, 32'h8000_0010, 1'b0, 4'b1111, 1'b1, 32'h0000_BEEF);
        expect_txn(1'b0, 32'hBFC0_0004, 1'b0, 4'b1111, 1'b1, 32'h3C1D_8000);
        fork
            m0_txn(32'hBFC0_0004);
            m1_txn(1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'b1111);
        join

        // 4: continuous M1 writes, M0 interleaves every second transaction
        expect_txn(1'b1, 32'h8000_0100, 1'b1, 4'b1111, 1'b0, 32'h0);
        expect_txn(1'b0, 32'hBFC0_0000, 1'b0, 4'b1111, 1'b1, 32'h2402_0005);
        expect_txn(1'b1, 32'h8000_0104, 1'b1, 4'b1111, 1'b0, 32'h0);
        expect_txn(1'b0, 32'hBFC0_0004, 1'b0, 4'b1111, 1'b1, 32'h3C1D_8000);
        expect_txn(1'b1, 32'h8000_0108, 1'b1, 4'b1111, 1'b0, 32'h0);
        expect_txn(1'b1, 32'h8000_010C, 1'b1, 4'b1111, 1'b0, 32'h0);
        fork
            begin
                for (int i = 0; i < 4; i++)
                    m1_txn(1'b0, 1'b1, 32'h8000_0100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'b1111);
            end
            begin
                m0_txn(32'hBFC0_0000);
                m0_txn(32'hBFC0_0004);
            end
        join
        expect_txn(1'b1, 32'h8000_0108, 1'b0, 4'b1111, 1'b1, 32'hA000_0002);
        m1_txn(1'b1, 1'b0, 32'h8000_0108, 32'h0, 4'b1111);

        // read and write together behaves as a write
        expect_txn(1'b1, 32'h8000_0030, 1'b1, 4'b1111, 1'b0, 32'h0);
        m1_txn(1'b1, 1'b1, 32'h8000_0030, 32'h5566_7788, 4'b1111);
        expect_txn(1'b1, 32'h8000_0030, 1'b0, 4'b1111, 1'b1, 32'h5566_7788);
        m1_txn(1'b1, 1'b0, 32'h8000_0030, 32'h0, 4'b1111);

        // 5: zero-wait build, ACK one cycle after the request
        begin
            exp_t ze;
            ze.master = 1'b1; ze.addr = 32'h0000_0004; ze.wr = 1'b0; ze.be = 4'b1111;
            ze.chk_data = 1'b1; ze.data = 32'hCAFE_F00D;
            zq.push_back(ze);
        end
        k = cyc;
        lat = -1;
        z_m1_address = 32'h0000_0004;
        z_m1_read = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (z_m1_waitrequest === 1'b0) begin
                lat = cyc - k;
                break;
            end
        end
        chk("t5_latency", 32'(lat), 32'd1);
        @(posedge clk);
        #1;
        z_m1_read = 1'b0;

        // 6: reset during WAIT aborts the write
        m1_address = 32'h8000_0020;
        m1_writedata = 32'hAAAA_AAAA;
        m1_byteenable = 4'b1111;
        m1_write = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_s_write_granted", 32'(s_write), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_s_write_reset", 32'(s_write), 32'd0);
        chk("t6_s_waitrequest_reset", 32'(s_waitrequest), 32'd1);
        chk("t6_m1_waitrequest_reset", 32'(m1_waitrequest), 32'd1);
        m1_write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        expect_txn(1'b1, 32'h8000_0020, 1'b0, 4'b1111, 1'b1, 32'h1122_3344);
        m1_txn(1'b1, 1'b0, 32'h8000_0020, 32'h0, 4'b1111);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("zq_drained", 32'(zq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
